// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_serializer block.
package piso_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } piso_state_e;

    // $clog2 with a floor of one bit so a counter port is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned lg;
        lg = int'($clog2(w));
        return (lg < 1) ? 1 : lg;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake, bit-rate strobe and serial/status bundle for piso_serializer.
interface piso_serializer_if
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    localparam int unsigned CntW = cnt_width(WIDTH);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] parallel_in;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shift_reg;
    logic [CntW-1:0]  bit_cnt;

    // Producer / line side.
    modport master (
        output load_valid,
        output parallel_in,
        output shift_en,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  busy,
        input  done,
        input  shift_reg,
        input  bit_cnt
    );

    // Serializer side.
    modport slave (
        input  load_valid,
        input  parallel_in,
        input  shift_en,
        output load_ready,
        output serial_out,
        output serial_valid,
        output busy,
        output done,
        output shift_reg,
        output bit_cnt
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-Width bit index counter with clear, enable and terminal-count flag.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned CntW  = cnt_width(Width)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [CntW-1:0] cnt_o,
    output logic            tc_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == CntW'(Width - 1));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parametrised PISO with valid/ready load, bit-rate enable and gapless reload.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input logic clk,
    input logic rst,
    piso_serializer_if.slave bus
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic             done_q, done_d;
    logic [CntW-1:0]  bit_cnt;
    logic             cnt_tc, cnt_en, cnt_clr;
    logic             data_last, last_bit, load_ready, accept;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    piso_bit_counter #(
        .Width (WIDTH),
        .CntW  (CntW)
    ) u_bit_counter (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (bit_cnt),
        .tc_o  (cnt_tc)
    );

    // Handshake, last-bit detect and datapath next-state.
    always_comb begin
        data_last = (state_q == StShift) && cnt_tc && bus.shift_en;
`ifdef PISO_PARITY_EN
        last_bit  = (state_q == StParity) && bus.shift_en;
        // Counter parks on WIDTH-1 while the parity bit is on the line.
        cnt_en    = (state_q == StShift) && bus.shift_en && !cnt_tc;
`else
        last_bit  = data_last;
        cnt_en    = (state_q == StShift) && bus.shift_en;
`endif
        load_ready = (state_q == StIdle) || last_bit;
        accept     = bus.load_valid && load_ready;
        cnt_clr    = accept || last_bit;
        done_d     = last_bit;

        shift_reg_d = shift_reg_q;
        if (accept) begin
            shift_reg_d = bus.parallel_in;
        end else if ((state_q == StShift) && bus.shift_en) begin
            if (MSB_FIRST) begin
                shift_reg_d = {shift_reg_q[WIDTH-2:0], 1'b0};
            end else begin
                shift_reg_d = {1'b0, shift_reg_q[WIDTH-1:1]};
            end
        end

`ifdef PISO_PARITY_EN
        parity_d = accept ? ^bus.parallel_in : parity_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StShift;
            end
            StShift: begin
                if (accept) begin
                    state_d = StShift;
                end else if (data_last) begin
`ifdef PISO_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                if (accept) begin
                    state_d = StShift;
                end else if (last_bit) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_reg_q <= '0;
            done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            done_q      <= done_d;
`ifdef PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // serial_out comes straight off the register, no retiming flop.
    always_comb begin
        bus.serial_out = IDLE_BIT;
        unique case (state_q)
            StIdle:  bus.serial_out = IDLE_BIT;
            StShift: bus.serial_out = MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0];
`ifdef PISO_PARITY_EN
            StParity: bus.serial_out = parity_q;
`endif
            default: bus.serial_out = IDLE_BIT;
        endcase
        bus.serial_valid = (state_q != StIdle);
        bus.busy         = (state_q != StIdle);
        bus.load_ready   = load_ready;
        bus.done         = done_q;
        bus.shift_reg    = shift_reg_q;
        bus.bit_cnt      = bit_cnt;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register, the next generation of the team's fixed 4-bit PISO.
- Adds a valid/ready load handshake, a bit-rate enable, selectable shift direction, frame status and gapless back-to-back frames.
- Sits between a word-wide producer (register file or FIFO) and a 1-bit serial line or link transmitter.

Parameters:
- WIDTH, 8: parallel word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_BIT, 1'b0: serial_out level while no frame is active.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  producer has a word on parallel_in
- load_ready  out  1  block accepts a word this cycle
- parallel_in  in  WIDTH  word to serialise; sampled on accept
- shift_en  in  1  bit-rate strobe; one bit advances per cycle it is high
- serial_out  out  1  current serial bit
- serial_valid  out  1  high while serial_out carries frame data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final bit of a frame is consumed
- shift_reg  out  WIDTH  internal shift register, exported for observability
- bit_cnt  out  $clog2(WIDTH)  index of the bit currently on serial_out

Behaviour:
- Reset (synchronous, active-high, highest priority; aborts any frame):
  - state=IDLE, shift_reg=0, bit_cnt=0, done=0
  - serial_out=IDLE_BIT, serial_valid=0, busy=0, load_ready=1
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- Accept: occurs when load_valid && load_ready.
  - On that edge: shift_reg<=parallel_in, bit_cnt<=0, state<=SHIFT.
  - First bit appears on serial_out the cycle after accept, so latency is 1 cycle.
- serial_out in SHIFT = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0]; driven directly from the register with no extra flop.
- In SHIFT with shift_en=1:
  - shift_reg shifts toward the output end, zero-filling the vacated end.
  - bit_cnt increments.
- In SHIFT with shift_en=0: everything holds; the current bit persists on serial_out.
- Last bit: defined as bit_cnt==WIDTH-1 && shift_en.
  - Next cycle: done=1 for exactly one cycle.
  - Next cycle: state returns to IDLE, unless a new word is accepted on the same edge.
- load_ready = (state==IDLE) || (last bit consumed this cycle). The second term gives gapless frames.
  - A back-to-back accept makes the new frame's first bit follow the old frame's last bit with zero idle cycles.
  - done still pulses for the old frame.
- A load_valid asserted while busy and not on the last bit is not accepted. parallel_in is ignored and the producer must hold its word.
- shift_en is ignored in IDLE. bit_cnt wraps to 0 on frame end and never exceeds WIDTH-1.
- busy = serial_valid = (state!=IDLE).

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit, the XOR of parallel_in captured at accept, is sent after the last data bit in state PARITY. The frame is therefore WIDTH+1 bit-times.
  - PARITY consumes one shift_en.
  - "Last bit" moves to the PARITY bit, so load_ready, done and gapless reload all refer to it.
  - bit_cnt holds WIDTH-1 during PARITY.
- Undefined: the PARITY state, parity flop and logic are absent; frames are exactly WIDTH bits.

Decomposition:
- Package piso_pkg holds:
  - the state typedef (IDLE, SHIFT, PARITY)
  - the function for counter width ($clog2 wrapper with a minimum of 1)
- One sub-module is natural: piso_bit_counter, a modulo-WIDTH counter with enable, clear, and a terminal-count output that drives the last-bit detect.
- The shift register and FSM stay in the top.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> serial_out=IDLE_BIT, busy=0, load_ready=1, shift_reg=0.
2. WIDTH=4, MSB_FIRST=1, load 4'b1011, shift_en=1 continuously -> serial_out 1,0,1,1 on the 4 cycles after accept; done pulses once on the 5th cycle; load_ready=0 during bits 0-2.
3. WIDTH=4, MSB_FIRST=0, load 4'b1011 -> serial_out 1,1,0,1.
4. Stall: shift_en toggled 1,0,0,1,1,1 -> bit_cnt and serial_out hold while shift_en=0; frame completes after exactly 4 enabled cycles.
5. Back-to-back: 4'b1011 then 4'b1100, with load_valid held -> second word accepted on the last-bit cycle; serial_out 1,0,1,1,1,1,0,0 contiguous; two done pulses 4 cycles apart.
6. Reset mid-frame, then parity:
   - rst during bit 2 -> next cycle busy=0, serial_out=IDLE_BIT.
   - Then with PISO_PARITY_EN, load 4'b1011 -> 1,0,1,1 followed by parity bit 1; done after 5 bits.
